fifo_byte_reader: RTL and testbench
===================================

// Module: fifo_byte_reader
// PURPOSE
//  Read-side drain for the shared capture FIFO, on cwusb_clk. Prefetches 18-bit words from
//  the FIFO read port (non-fallthrough: data valid 1 cycle after read) and serves them to
//  reg_main as a byte stream, 3 bytes/word. Two word registers (cur, next) support
//  back-to-back host byte reads. Sits between the FIFO read port and reg_main's FIFO data register.
// PARAMETERS
//  pTAG          2'b10   framing tag in byte0[7:6]
//  pEMPTY_BYTE   8'h00   byte returned when no word is held (underrun)
//  pCNT_WIDTH    32      width of the stats counters
// PORTS
//  cwusb_clk        in   1          sole clock
//  reset_i          in   1          synchronous, active-high reset
//  I_fifo_empty     in   1          FIFO empty
//  I_fifo_data      in   18         FIFO dout, valid 1 cycle after O_fifo_read
//  O_fifo_read      out  1          FIFO rd_en, single-cycle pulses
//  I_byte_rd        in   1          pulse: host consumed O_byte this cycle
//  O_byte           out  8          byte presented for the next host read
//  O_byte_valid     out  1          O_byte is word data (0 -> pEMPTY_BYTE)
//  I_flush          in   1          pulse: discard held and in-flight words
//  I_clear_errors   in   1          pulse: clear O_underrun
//  O_underrun       out  1          sticky: I_byte_rd while O_byte_valid=0
//  O_words_read     out  pCNT_WIDTH words fully consumed (stats)
//  O_underrun_cnt   out  pCNT_WIDTH underrun reads (stats)
// BEHAVIOUR
//  - Reset: O_fifo_read=0, O_byte=pEMPTY_BYTE, O_byte_valid=0, O_underrun=0, counters=0,
//    cur/next invalid, byte index=0, in-flight flag=0; data from a pre-reset read is dropped.
//  - Byte order per word: byte0={pTAG,4'b0,d[17:16]}, byte1=d[15:8], byte2=d[7:0].
//  - O_byte/O_byte_valid are registered from cur word and byte index; stable until I_byte_rd.
//  - Prefetch: O_fifo_read=1 iff !I_fifo_empty & !inflight & !flush & (!cur_v | !next_v).
//    Cycle after read: inflight=0, capture I_fifo_data into cur if cur empty (or being vacated
//    this cycle), else into next. At most one read in flight.
//  - I_byte_rd with valid: index 0->1->2; on index 2, cur<=next (or invalid), index<=0,
//    O_words_read++. New cur byte0 presented the following cycle; back-to-back I_byte_rd each
//    cycle sustains 3 bytes/word without underrun while FIFO non-empty.
//  - I_byte_rd with !O_byte_valid: O_underrun<=1, O_underrun_cnt++, no state change.
//  - I_flush: cur/next invalid, index=0, in-flight data next cycle discarded, no O_fifo_read
//    in flush cycle. Flush with simultaneous I_byte_rd: flush wins, no underrun counted.
//  - I_clear_errors clears O_underrun; a same-cycle underrun wins (stays 1).
//  - Counters saturate at all-ones, cleared only by reset.
//  - Empty boundary: FIFO empty with cur valid -> remaining bytes served; then O_byte_valid=0.
// CONFIGURATION
//  - FIFO_READER_STATS_EN defined: O_words_read and O_underrun_cnt implemented as above.
//  - Not defined: both tied to 0, counter logic absent; O_underrun sticky still present.
// TESTING
//  - Reset, FIFO empty -> O_byte=8'h00, O_byte_valid=0, O_fifo_read never asserted.
//  - Load 18'h2_A5C3; read 3 bytes -> 8'h82, 8'hA5, 8'hC3; O_words_read=1.
//  - Load 4 words, I_byte_rd every cycle for 12 cycles -> 12 correct bytes, O_underrun=0.
//  - 1 word, 4 reads -> 4th read O_underrun=1, O_underrun_cnt=1; I_clear_errors -> 0.
//  - Load 3 words, read 1 byte, I_flush -> O_byte_valid=0 next cycle; next prefetch returns
//    word 3 (words 1-2 discarded), byte0=8'h8x.
//  - reset_i asserted mid-word with read in flight -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_byte_reader_if.sv
// Byte-reader bundle: FIFO read port, host byte port, control pulses and status.
// slave = the reader itself, master = whoever drives the FIFO and host sides.
interface fifo_byte_reader_if #(
   parameter int pCNT_WIDTH = 32
);
   logic                  I_fifo_empty;
   logic [17:0]           I_fifo_data;
   logic                  O_fifo_read;
   logic                  I_byte_rd;
   logic [7:0]            O_byte;
   logic                  O_byte_valid;
   logic                  I_flush;
   logic                  I_clear_errors;
   logic                  O_underrun;
   logic [pCNT_WIDTH-1:0] O_words_read;
   logic [pCNT_WIDTH-1:0] O_underrun_cnt;

   modport slave (
      input  I_fifo_empty, I_fifo_data, I_byte_rd, I_flush, I_clear_errors,
      output O_fifo_read, O_byte, O_byte_valid, O_underrun, O_words_read, O_underrun_cnt
   );

   modport master (
      output I_fifo_empty, I_fifo_data, I_byte_rd, I_flush, I_clear_errors,
      input  O_fifo_read, O_byte, O_byte_valid, O_underrun, O_words_read, O_underrun_cnt
   );
endinterface

// File: rtl/fifo_byte_reader.sv
// Drains 18-bit capture-FIFO words into a 3-bytes-per-word host stream with two-word prefetch.
// Define FIFO_READER_STATS_EN to build the words-read / underrun statistics counters.
module fifo_byte_reader #(
   parameter logic [1:0] pTAG        = 2'b10,
   parameter logic [7:0] pEMPTY_BYTE = 8'h00,
   parameter int         pCNT_WIDTH  = 32
) (
   input  logic               cwusb_clk,
   input  logic               reset_i,
   fifo_byte_reader_if.slave  bus
);

   logic [17:0] r_cur, r_nxt;
   logic        r_cur_v, r_nxt_v, r_inflight;
   logic [1:0]  r_idx;
   logic [7:0]  r_byte;
   logic        r_byte_v;
   logic        r_underrun;

   logic        w_fetch, w_rd_ok, w_under, w_vacate;
   logic [17:0] w_cur_d, w_nxt_d;
   logic        w_cur_v_d, w_nxt_v_d;
   logic [1:0]  w_idx_d;

   function automatic logic [7:0] word_byte(input logic [17:0] d, input logic [1:0] idx);
      case (idx)
         2'd0:    word_byte = {pTAG, 4'b0000, d[17:16]};
         2'd1:    word_byte = d[15:8];
         default: word_byte = d[7:0];
      endcase
   endfunction

   // Reset also gates the read strobe so no word is popped into a state that is being cleared.
   assign w_fetch  = !reset_i && !bus.I_fifo_empty && !r_inflight && !bus.I_flush
                     && (!r_cur_v || !r_nxt_v);
   assign w_rd_ok  = bus.I_byte_rd && r_byte_v && !bus.I_flush;
   assign w_under  = bus.I_byte_rd && !r_byte_v && !bus.I_flush;
   assign w_vacate = w_rd_ok && (r_idx == 2'd2);

   always_comb begin
      w_cur_d   = r_cur;
      w_cur_v_d = r_cur_v;
      w_nxt_d   = r_nxt;
      w_nxt_v_d = r_nxt_v;
      w_idx_d   = r_idx;
      if (bus.I_flush) begin
         w_cur_v_d = 1'b0;
         w_nxt_v_d = 1'b0;
         w_idx_d   = 2'd0;
      end else begin
         if (w_rd_ok) begin
            if (w_vacate) begin
               w_cur_d   = r_nxt;
               w_cur_v_d = r_nxt_v;
               w_nxt_v_d = 1'b0;
               w_idx_d   = 2'd0;
            end else begin
               w_idx_d = r_idx + 2'd1;
            end
         end
         // Returning word fills whichever slot is free after this cycle's consumption.
         if (r_inflight) begin
            if (!w_cur_v_d) begin
               w_cur_d   = bus.I_fifo_data;
               w_cur_v_d = 1'b1;
            end else begin
               w_nxt_d   = bus.I_fifo_data;
               w_nxt_v_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge cwusb_clk) begin
      if (reset_i) begin
         r_cur_v    <= 1'b0;
         r_nxt_v    <= 1'b0;
         r_inflight <= 1'b0;
         r_idx      <= 2'd0;
         r_byte     <= pEMPTY_BYTE;
         r_byte_v   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_cur_v    <= w_cur_v_d;
         r_nxt_v    <= w_nxt_v_d;
         r_inflight <= w_fetch;
         r_idx      <= w_idx_d;
         r_byte     <= w_cur_v_d ? word_byte(w_cur_d, w_idx_d) : pEMPTY_BYTE;
         r_byte_v   <= w_cur_v_d;
         r_underrun <= w_under || (r_underrun && !bus.I_clear_errors);
      end
   end

   always_ff @(posedge cwusb_clk) begin
      r_cur <= w_cur_d;
      r_nxt <= w_nxt_d;
   end

   assign bus.O_fifo_read  = w_fetch;
   assign bus.O_byte       = r_byte;
   assign bus.O_byte_valid = r_byte_v;
   assign bus.O_underrun   = r_underrun;

`ifdef FIFO_READER_STATS_EN
   logic [pCNT_WIDTH-1:0] r_words_read, r_underrun_cnt;

   function automatic logic [pCNT_WIDTH-1:0] sat_inc(input logic [pCNT_WIDTH-1:0] v);
      sat_inc = (&v) ? v : v + {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   always_ff @(posedge cwusb_clk) begin
      if (reset_i) begin
         r_words_read   <= '0;
         r_underrun_cnt <= '0;
      end else begin
         if (w_vacate) r_words_read   <= sat_inc(r_words_read);
         if (w_under)  r_underrun_cnt <= sat_inc(r_underrun_cnt);
      end
   end

   assign bus.O_words_read   = r_words_read;
   assign bus.O_underrun_cnt = r_underrun_cnt;
`else
   assign bus.O_words_read   = '0;
   assign bus.O_underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: queue-backed FIFO, word/byte-level reference model, directed and random reads.
module tb_fifo_byte_reader;
   logic clk = 1'b0;
   logic rst;

   fifo_byte_reader_if #(.pCNT_WIDTH(32)) bus ();

   fifo_byte_reader #(
      .pTAG(2'b10), .pEMPTY_BYTE(8'h00), .pCNT_WIDTH(32)
   ) dut (
      .cwusb_clk (clk),
      .reset_i   (rst),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   // Non-fallthrough FIFO: data appears the cycle after a sampled read strobe.
   logic [17:0] mem [0:1023];
   int          n_push, n_pop, rd_empty;
   logic [17:0] fifo_q;

   assign bus.I_fifo_empty = (n_push == n_pop);
   assign bus.I_fifo_data  = fifo_q;

   always @(posedge clk) begin
      if (bus.O_fifo_read === 1'b1) begin
         if (n_push != n_pop) begin
            fifo_q <= mem[n_pop % 1024];
            n_pop  <= n_pop + 1;
         end else begin
            rd_empty <= rd_empty + 1;
         end
      end
   end

   // Reference model: words still owed to the host, byte position within the head word.
   logic [17:0] mq[$];
   int          mbi, m_words, m_ucnt;
   logic        m_under;
   int          n_checks, n_err;

   function automatic logic [7:0] exp_byte(input logic [17:0] w, input int i);
      if (i == 0)      return {2'b10, 4'b0000, w[17:16]};
      else if (i == 1) return w[15:8];
      else             return w[7:0];
   endfunction

   function automatic logic [31:0] exp_cnt(input int v);
`ifdef FIFO_READER_STATS_EN
      return 32'(v);
`else
      return (v >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [17:0] w);
      mem[n_push % 1024] = w;
      n_push++;
      mq.push_back(w);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Checks the presented byte, asserts I_byte_rd for one edge and leaves it high.
   task automatic host_read(input string tag);
      logic ev;
      ev = (mq.size() > 0);
      chk({tag, "_vld"}, 32'(bus.O_byte_valid), 32'(ev));
      chk({tag, "_byte"}, 32'(bus.O_byte), ev ? 32'(exp_byte(mq[0], mbi)) : 32'h00);
      bus.I_byte_rd = 1'b1;
      @(negedge clk);
      if (ev) begin
         mbi++;
         if (mbi == 3) begin
            void'(mq.pop_front());
            mbi = 0;
            m_words++;
         end
      end else begin
         m_under = 1'b1;
         m_ucnt++;
      end
   endtask

   task automatic burst(input int n, input string tag);
      for (int i = 0; i < n; i++) host_read(tag);
      bus.I_byte_rd = 1'b0;
   endtask

   task automatic chk_stat(input string tag);
      chk({tag, "_underrun"}, 32'(bus.O_underrun), 32'(m_under));
      chk({tag, "_words"}, bus.O_words_read, exp_cnt(m_words));
      chk({tag, "_ucnt"}, bus.O_underrun_cnt, exp_cnt(m_ucnt));
   endtask

   task automatic clear_pulse();
      bus.I_clear_errors = 1'b1;
      @(negedge clk);
      bus.I_clear_errors = 1'b0;
      m_under = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_byte"}, 32'(bus.O_byte), 32'h00);
      chk({tag, "_vld"}, 32'(bus.O_byte_valid), 32'h0);
      chk({tag, "_rd"}, 32'(bus.O_fifo_read), 32'h0);
      chk({tag, "_underrun"}, 32'(bus.O_underrun), 32'h0);
      chk({tag, "_words"}, bus.O_words_read, 32'h0);
      chk({tag, "_ucnt"}, bus.O_underrun_cnt, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int np, nr;
      rst = 1'b1;
      bus.I_byte_rd = 1'b0;
      bus.I_flush = 1'b0;
      bus.I_clear_errors = 1'b0;
      mbi = 0; m_words = 0; m_ucnt = 0; m_under = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      settle(5);
      chk("idle_rd", 32'(bus.O_fifo_read), 32'h0);
      chk("idle_vld", 32'(bus.O_byte_valid), 32'h0);

      push(18'h2_A5C3);
      settle(6);
      chk("one_b0_const", 32'(bus.O_byte), 32'h82);
      burst(3, "one");
      chk_stat("one");

      for (int k = 0; k < 4; k++) push(18'($urandom));
      settle(6);
      burst(12, "four");
      chk_stat("four");

      push(18'($urandom));
      settle(6);
      burst(4, "under");
      chk_stat("under");
      clear_pulse();
      chk_stat("clr");

      bus.I_clear_errors = 1'b1;
      host_read("clr_same");
      bus.I_clear_errors = 1'b0;
      bus.I_byte_rd = 1'b0;
      chk_stat("clr_same");
      clear_pulse();

      bus.I_flush = 1'b1;
      bus.I_byte_rd = 1'b1;
      @(negedge clk);
      bus.I_flush = 1'b0;
      bus.I_byte_rd = 1'b0;
      chk_stat("flush_rd");

      push(18'h0_1111);
      push(18'h3_2222);
      push(18'h1_3C5A);
      settle(6);
      burst(1, "fl");
      bus.I_flush = 1'b1;
      @(negedge clk);
      bus.I_flush = 1'b0;
      void'(mq.pop_front());
      void'(mq.pop_front());
      mbi = 0;
      chk("fl_vld", 32'(bus.O_byte_valid), 32'h0);
      settle(4);
      chk("fl_w3_b0", 32'(bus.O_byte), 32'h81);
      burst(3, "fl_w3");
      chk_stat("fl");

      for (int k = 0; k < 3; k++) push(18'($urandom));
      settle(6);
      burst(3, "rs_w1");
      chk("rs_prefetch", 32'(bus.O_fifo_read), 32'h1);
      host_read("rs_w2");
      bus.I_byte_rd = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("rs");
      rst = 1'b0;
      mq.delete();
      mbi = 0; m_words = 0; m_ucnt = 0; m_under = 1'b0;
      push(18'h2_0F0E);
      settle(6);
      burst(3, "rs_new");
      chk_stat("rs_new");

      for (int it = 0; it < 25; it++) begin
         np = $urandom_range(0, 2);
         for (int k = 0; k < np; k++) push(18'($urandom));
         settle(6);
         nr = $urandom_range(1, 8);
         burst(nr, "rnd");
         chk_stat("rnd");
         if ($urandom_range(0, 3) == 0) clear_pulse();
      end

      chk("no_read_when_empty", 32'(rd_empty), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
